// File: rtl/add_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// add_share_ctrl_if
// Handshake/operand bundle between the two requesting units and the shared
// adder scheduler (add_share_ctrl).
//
// Signals:
//   req0, a0, b0   requester 0 request (held until ack0) and 16-bit operands
//   req1, a1, b1   requester 1 request (held until ack1) and 16-bit operands
//   sel            operand mux select, 0 = requester 0, 1 = requester 1
//   busy           scheduler is in CALC or DONE
//   ack0, ack1     one-cycle completion pulse to the granted requester
//   sum, cout      registered 17-bit result of the granted requester's a+b
//
// Modports:
//   master  requester side (drives requests and operands)
//   slave   scheduler side (drives select, status, acks and result)
// -----------------------------------------------------------------------------
interface add_share_ctrl_if;
    logic        req0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        req1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        sel;
    logic        busy;
    logic        ack0;
    logic        ack1;
    logic [15:0] sum;
    logic        cout;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  sel, busy, ack0, ack1, sum, cout
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output sel, busy, ack0, ack1, sum, cout
    );
endinterface

// File: rtl/add_share_ctrl.sv
// -----------------------------------------------------------------------------
// add_share_ctrl
// Two-requester scheduler for the shared 16-bit adder. Picks a winner in IDLE,
// registers the operand mux select, computes a+b of the winner in CALC, and
// returns the registered result with a one-cycle ack in DONE. One transaction
// completes every 3 cycles.
//
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous, active-high reset
//   s_bus   add_share_ctrl_if.slave (requests/operands in, sel/busy/acks/
//           sum/cout out)
//
// Build option:
//   ADD_SHARE_RR_EN  defined   -> round-robin tie break with a 1-bit pointer
//                    undefined -> fixed priority, requester 0 wins ties
//
// State table:
//   state   | meaning
//   IDLE    | waiting for a request; grant and register sel on exit
//   CALC    | operands of sel pass through the mux; result registered
//   DONE    | result valid, ack pulse to the sel requester
// -----------------------------------------------------------------------------
module add_share_ctrl (
    input  logic               i_clk,
    input  logic               i_rst,
    add_share_ctrl_if.slave    s_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_sel;
    logic        r_busy;
    logic        r_ack0;
    logic        r_ack1;
    logic [15:0] r_sum;
    logic        r_cout;

    logic        w_any_req;
    logic        w_grant1;
    logic [15:0] w_op_a;
    logic [15:0] w_op_b;
    logic [16:0] w_sum;

    assign w_any_req = s_bus.req0 | s_bus.req1;

`ifdef ADD_SHARE_RR_EN
    logic r_ptr;

    // Requester 1 wins when alone, or on a tie when the pointer prefers it.
    assign w_grant1 = s_bus.req1 & (~s_bus.req0 | r_ptr);
`else
    assign w_grant1 = s_bus.req1 & ~s_bus.req0;
`endif

    // Shared 2:1 operand mux, steered by the registered select only.
    assign w_op_a = r_sel ? s_bus.a1 : s_bus.a0;
    assign w_op_b = r_sel ? s_bus.b1 : s_bus.b0;
    assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_sum   <= 16'h0000;
            r_cout  <= 1'b0;
`ifdef ADD_SHARE_RR_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (w_any_req) begin
                        r_sel   <= w_grant1;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
`ifdef ADD_SHARE_RR_EN
                        r_ptr   <= ~w_grant1;
`endif
                    end
                end
                ST_CALC: begin
                    // Acks are registered here so they are high for the
                    // whole DONE cycle alongside the fresh result.
                    r_sum   <= w_sum[15:0];
                    r_cout  <= w_sum[16];
                    r_ack0  <= ~r_sel;
                    r_ack1  <= r_sel;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_bus.sel  = r_sel;
    assign s_bus.busy = r_busy;
    assign s_bus.ack0 = r_ack0;
    assign s_bus.ack1 = r_ack1;
    assign s_bus.sum  = r_sum;
    assign s_bus.cout = r_cout;

endmodule

// File: tb/tb_add_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_share_ctrl
// Directed scenarios followed by randomized requester traffic, every cycle
// compared against a transaction-level reference model of the scheduler.
// -----------------------------------------------------------------------------
module tb_add_share_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    add_share_ctrl_if bus ();

    add_share_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Reference model: one transaction occupies three cycles (grant-idle,
    // calc, done). m_phase counts position inside the current transaction.
    int          m_phase;
    logic        m_sel, m_busy, m_ack0, m_ack1, m_cout, m_ptr;
    logic [15:0] m_sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n_cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_busy = 0; m_ack0 = 0; m_ack1 = 0;
        m_sum = 0; m_cout = 0; m_ptr = 0;
    endtask

    // Advance one clock: capture the inputs present at the edge, update the
    // model, then compare every output 1 ns after the edge.
    task automatic cycle();
        logic        q0, q1, rs, w;
        logic [15:0] x0, y0, x1, y1;
        logic [16:0] full;
        q0 = bus.req0; q1 = bus.req1; rs = rst;
        x0 = bus.a0; y0 = bus.b0; x1 = bus.a1; y1 = bus.b1;
        @(posedge clk);
        n_cyc++;
        if (rs) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_ack0 = 0; m_ack1 = 0;
            if (q0 || q1) begin
`ifdef ADD_SHARE_RR_EN
                w = (q0 && q1) ? m_ptr : q1;
`else
                w = q1 && !q0;
`endif
                m_sel = w; m_ptr = !w; m_busy = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            full = m_sel ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});
            m_sum = full[15:0]; m_cout = full[16];
            m_ack0 = !m_sel; m_ack1 = m_sel; m_phase = 2;
        end else begin
            m_ack0 = 0; m_ack1 = 0; m_busy = 0; m_phase = 0;
        end
        #1;
        check("sel",  32'(bus.sel),  32'(m_sel));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("ack0", 32'(bus.ack0), 32'(m_ack0));
        check("ack1", 32'(bus.ack1), 32'(m_ack1));
        check("sum",  32'(bus.sum),  32'(m_sum));
        check("cout", 32'(bus.cout), 32'(m_cout));
        check("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
    endtask

    initial begin
        int ack_seq[$];
        int ack_cyc[$];
        int n_ack;
        logic [15:0] ea;
        logic [16:0] esum;

        rst = 1; bus.req0 = 0; bus.req1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        model_reset();
        cycle(); cycle();
        check("rst_sel",  32'(bus.sel),  32'd0);
        check("rst_sum",  32'(bus.sum),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 0;

        // Single request from requester 0.
        bus.req0 = 1; bus.a0 = 16'h1234; bus.b0 = 16'h0001;
        cycle();
        check("t1_sel", 32'(bus.sel), 32'd0);
        check("t1_busy", 32'(bus.busy), 32'd1);
        cycle();
        check("t1_ack0", 32'(bus.ack0), 32'd1);
        check("t1_sum",  32'(bus.sum),  32'h1235);
        check("t1_cout", 32'(bus.cout), 32'd0);
        bus.req0 = 0;
        cycle(); cycle();

        // Carry case on requester 1.
        bus.req1 = 1; bus.a1 = 16'hFFFF; bus.b1 = 16'h0002;
        cycle();
        check("t2_sel", 32'(bus.sel), 32'd1);
        cycle();
        check("t2_ack1", 32'(bus.ack1), 32'd1);
        check("t2_sum",  32'(bus.sum),  32'h0001);
        check("t2_cout", 32'(bus.cout), 32'd1);
        bus.req1 = 0;
        cycle(); cycle();

        // Simultaneous held requests over four transactions.
        bus.req0 = 1; bus.a0 = 16'h0010; bus.b0 = 16'h0020;
        bus.req1 = 1; bus.a1 = 16'h0100; bus.b1 = 16'h0200;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.ack0) begin ack_seq.push_back(0); ack_cyc.push_back(n_cyc); end
            if (bus.ack1) begin ack_seq.push_back(1); ack_cyc.push_back(n_cyc); end
        end
        bus.req0 = 0; bus.req1 = 0;
        check("t3_nacks", 32'(ack_seq.size()), 32'd4);
        if (ack_seq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef ADD_SHARE_RR_EN
                check("t3_order", 32'(ack_seq[i]), 32'(i % 2));
`else
                check("t3_order", 32'(ack_seq[i]), 32'd0);
`endif
                if (i > 0) check("t3_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
            end
        end
        cycle(); cycle(); cycle();

        // Back-to-back requester 0 with operands changing after each ack.
        bus.req0 = 1; bus.a0 = 16'h8000; bus.b0 = 16'h8001;
        esum = 17'h10001;
        n_ack = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (bus.ack0) begin
                n_ack++;
                check("t4_sum", 32'({bus.cout, bus.sum}), 32'(esum));
                ea = 16'($urandom);
                bus.a0 = ea; bus.b0 = 16'(n_ack * 16'h1111);
                esum = {1'b0, ea} + {1'b0, bus.b0};
            end
        end
        check("t4_nack", 32'(n_ack), 32'd3);
        bus.req0 = 0;
        cycle(); cycle(); cycle();

        // Reset during CALC.
        bus.req0 = 1; bus.a0 = 16'h1111; bus.b0 = 16'h2222;
        cycle();
        rst = 1; bus.req0 = 0;
        cycle();
        check("t5_ack0", 32'(bus.ack0), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_sum",  32'(bus.sum),  32'd0);
        bus.req1 = 1; bus.a1 = 16'h0003; bus.b1 = 16'h0004;
        rst = 0;
        cycle();
        check("t5_sel", 32'(bus.sel), 32'd1);
        cycle();
        check("t5_ack1", 32'(bus.ack1), 32'd1);
        check("t5_res",  32'(bus.sum),  32'h0007);
        bus.req1 = 0;
        cycle();

        // Randomized requester traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(99) == 0);
            cycle();
            if (bus.req0 && m_ack0) begin
                bus.req0 = $urandom_range(1);
                bus.a0 = 16'($urandom); bus.b0 = 16'($urandom);
            end else if (!bus.req0 && $urandom_range(2) == 0) begin
                bus.req0 = 1; bus.a0 = 16'($urandom); bus.b0 = 16'($urandom);
            end
            if (bus.req1 && m_ack1) begin
                bus.req1 = $urandom_range(1);
                bus.a1 = 16'($urandom); bus.b1 = 16'($urandom);
            end else if (!bus.req1 && $urandom_range(2) == 0) begin
                bus.req1 = 1; bus.a1 = 16'($urandom); bus.b1 = 16'($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_share_ctrl.md
# add_share_ctrl

Two-requester scheduler for the shared 16-bit adder datapath. Arbitrates between requester 0 and requester 1, drives the select of the 16-bit 2:1 operand multiplexer, and registers the adder result. Returns the result to the winning requester with a one-cycle acknowledge. It sits between the two requesting units and the single adder/mux pair in the adder module.

## Interface
- No parameters; datapath width fixed at 16.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request; held until ack0
- a0, b0  input  16 each  requester 0 operands; stable while req0 high
- req1  input  1  requester 1 request; held until ack1
- a1, b1  input  16 each  requester 1 operands; stable while req1 high
- sel  output  1  operand mux select: 0 = requester 0, 1 = requester 1
- busy  output  1  high in CALC and DONE
- ack0, ack1  output  1 each  one-cycle completion pulse to the winning requester
- sum  output  16  registered a+b of the granted requester
- cout  output  1  carry out, bit 16 of the 17-bit sum

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner, register sel = winner, and go to CALC.
- CALC:
  - Operands pass through the 2:1 mux using the registered sel.
  - {cout,sum} <= a_sel + b_sel, computed at 17-bit width with no carry-in.
  - Go to DONE.
- DONE:
  - Assert ack of the sel requester for exactly this cycle.
  - sum and cout are valid this cycle.
  - Go to IDLE.
- sum, cout and sel hold their values outside update cycles.
- Winner selection:
  - Only one request high: that requester wins.
  - Both high: decided by the priority rule (see Configuration).
- A request that drops before its ack is a protocol violation. The transaction still completes using whatever operands are present during CALC.
- A request that stays high after its ack is treated as a new transaction in the next IDLE cycle (back-to-back issue).
- Reset at any point:
  - Return to IDLE and emit no ack.
  - sel=0, busy=0, ack0=ack1=0, sum=0, cout=0, priority pointer=0.

## Timing
- Request sampled high in IDLE at cycle N: CALC at N+1, DONE/ack at N+2.
- Latency is 2 cycles from grant to ack.
- Earliest next grant is at N+3, so one transaction completes every 3 cycles.
- sel changes only on the clock edge that leaves IDLE with a grant.
- ack0 and ack1 are never high together and are never high outside DONE.
- busy is high during N+1 and N+2.
- Requests arriving in CALC or DONE wait; they are evaluated in the next IDLE.

## Configuration
- Macro: ADD_SHARE_RR_EN.
- Defined (round-robin priority):
  - A 1-bit pointer names the preferred requester; reset value 0.
  - Ties go to the pointer requester.
  - After any grant to k, the pointer becomes 1-k.
- Undefined (fixed priority):
  - Requester 0 always wins ties; no pointer register exists.
  - Requester 1 can starve while req0 stays high.

## Test plan
- Reset then single request: req0=1, a0=16'h1234, b0=16'h0001.
  - Expect sel=0, ack0 pulse 2 cycles after grant, sum=16'h1235, cout=0, ack1 never high.
- Carry case on requester 1: req1=1, a1=16'hFFFF, b1=16'h0002.
  - Expect sel=1, ack1 pulse, sum=16'h0001, cout=1.
- Simultaneous held requests, 4 transactions, ADD_SHARE_RR_EN defined.
  - Expect ack order 0,1,0,1, acks 3 cycles apart.
  - Without the macro, expect all four acks on requester 0.
- Back-to-back: req0 held high over 3 transactions with operands changing after each ack.
  - Expect each sum to match the operands present in its CALC cycle.
  - Expect exactly one ack0 per 3 cycles.
- Reset mid-operation: assert rst during CALC.
  - Expect no ack, and all outputs 0 in the next cycle.
  - With rst low again and req1 high, expect the first grant to complete normally with sel=1.
